consumer_checker: RTL and testbench

CONSUMER_CHECKER -- requirements
Module: consumer_checker

---
 rtl/consumer_checker.sv | 162 ++++++++++++++++
 tb/tb_consumer_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/consumer_checker.sv
// Dual-lane consumer: each lane buffers beats in a small FIFO and checks the popped stream
// against its expected arithmetic sequence, reporting backpressure, errors and match counts.
module consumer_checker #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pipeline1_outputs,
    input  logic [31:0] pipeline2_outputs,
    input  logic [1:0]  out_valid,
    input  logic        flush_1,
    input  logic        flush_2,
    input  logic [1:0]  drain_en,
    output logic        stall_1,
    output logic        stall_2,
    output logic [1:0]  locked,
    output logic [1:0]  err,
    output logic [1:0]  overflow,
    output logic [15:0] err_count_1,
    output logic [15:0] err_count_2,
    output logic [31:0] good_count_1,
    output logic [31:0] good_count_2
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StSync, StLocked} state_e;

    logic [31:0] lane_data [2];
    logic [1:0]  lane_flush;
    logic [1:0]  lane_stall;
    logic [15:0] lane_ecnt [2];
    logic [31:0] lane_gcnt [2];

    assign lane_data[0] = pipeline1_outputs;
    assign lane_data[1] = pipeline2_outputs;
    assign lane_flush   = {flush_2, flush_1};

    for (genvar k = 0; k < 2; k++) begin : g_lane
        // Lane 1 carries even values, lane 2 odd values.
        localparam logic Parity = (k == 1);

        logic [31:0]   mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        state_e        state_q, state_d;
        logic [31:0]   exp_q, exp_d;
        logic [31:0]   good_q, good_d;
        logic [15:0]   ecnt_q, ecnt_d;
        logic          err_q, err_d, ovf_q, ovf_d, stall_q, stall_d;
        logic          full, empty, push, pop, drop, wr_en, chk_err;
        logic [31:0]   head;
        logic [16:0]   esum;

        always_comb begin
            full     = (cnt_q == CW'(DEPTH));
            empty    = (cnt_q == '0);
            push     = out_valid[k] & ~lane_flush[k];
            pop      = drain_en[k] & ~empty & ~lane_flush[k];
            // A simultaneous pop frees the slot, so only a lone push into a full FIFO drops.
            drop     = push & full & ~pop;
            wr_en    = push & ~drop;
            head     = mem_q[rd_ptr_q];
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            state_d  = state_q;
            exp_d    = exp_q;
            good_d   = good_q;
            chk_err  = 1'b0;

            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
            else if (pop && !wr_en) cnt_d = cnt_q - CW'(1);

            if (pop) begin
                case (state_q)
                    StSync: begin
                        if (head[0] == Parity) begin
                            state_d = StLocked;
                            exp_d   = head + 32'd2;
                            good_d  = good_q + 32'd1;
                        end else begin
                            chk_err = 1'b1;
                        end
                    end
                    StLocked: begin
                        if (head == exp_q) begin
                            exp_d  = exp_q + 32'd2;
                            good_d = good_q + 32'd1;
                        end else begin
                            chk_err = 1'b1;
                            state_d = StSync;
                        end
                    end
                    default: state_d = StSync;
                endcase
            end

            if (lane_flush[k]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
                state_d  = StSync;
            end

            err_d   = err_q | chk_err;
            ovf_d   = ovf_q | drop;
            esum    = {1'b0, ecnt_q} + 17'(drop) + 17'(chk_err);
            ecnt_d  = esum[16] ? 16'hFFFF : esum[15:0];
            stall_d = (cnt_d >= CW'(STALL_THRESH));
        end

        always_ff @(posedge clk) begin
            if (wr_en) mem_q[wr_ptr_q] <= lane_data[k];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                state_q  <= StSync;
                exp_q    <= '0;
                good_q   <= '0;
                ecnt_q   <= '0;
                err_q    <= 1'b0;
                ovf_q    <= 1'b0;
                stall_q  <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                state_q  <= state_d;
                exp_q    <= exp_d;
                good_q   <= good_d;
                ecnt_q   <= ecnt_d;
                err_q    <= err_d;
                ovf_q    <= ovf_d;
                stall_q  <= stall_d;
            end
        end

        assign lane_stall[k] = stall_q;
        assign locked[k]     = (state_q == StLocked);
        assign err[k]        = err_q;
        assign overflow[k]   = ovf_q;
        assign lane_ecnt[k]  = ecnt_q;
        assign lane_gcnt[k]  = good_q;
    end

    assign stall_1      = lane_stall[0];
    assign stall_2      = lane_stall[1];
    assign err_count_1  = lane_ecnt[0];
    assign err_count_2  = lane_ecnt[1];
    assign good_count_1 = lane_gcnt[0];
    assign good_count_2 = lane_gcnt[1];

endmodule

// File: tb/tb_consumer_checker.sv
// Bench for consumer_checker: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with a mid-burst reset.
module tb_consumer_checker;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STALL_THRESH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] p1, p2;
    logic [1:0]  out_valid, drain_en;
    logic        flush_1, flush_2;
    logic        stall_1, stall_2;
    logic [1:0]  locked, err, overflow;
    logic [15:0] err_count_1, err_count_2;
    logic [31:0] good_count_1, good_count_2;

    int checks   = 0;
    int failures = 0;

    consumer_checker #(.DEPTH(DEPTH), .STALL_THRESH(STALL_THRESH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pipeline1_outputs(p1),
        .pipeline2_outputs(p2),
        .out_valid        (out_valid),
        .flush_1          (flush_1),
        .flush_2          (flush_2),
        .drain_en         (drain_en),
        .stall_1          (stall_1),
        .stall_2          (stall_2),
        .locked           (locked),
        .err              (err),
        .overflow         (overflow),
        .err_count_1      (err_count_1),
        .err_count_2      (err_count_2),
        .good_count_1     (good_count_1),
        .good_count_2     (good_count_2)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          m_lock [2];
    bit          m_err  [2];
    bit          m_ovf  [2];
    bit          m_stall[2];
    logic [31:0] m_exp  [2];
    logic [31:0] m_good [2];
    int          m_ecnt [2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int k, input logic [31:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic qpop(input int k, output logic [31:0] v);
        if (k == 0) v = q0.pop_front();
        else        v = q1.pop_front();
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_lock[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_stall[k] = 0;
            m_exp[k] = '0; m_good[k] = '0; m_ecnt[k] = 0;
        end
    endtask

    task automatic lane_step(input int k);
        logic [31:0] din, v;
        bit fl;
        int add;
        din = (k == 0) ? p1 : p2;
        fl  = (k == 0) ? flush_1 : flush_2;
        add = 0;
        if (fl) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_lock[k] = 0;
        end else begin
            if (drain_en[k] && qsize(k) > 0) begin
                qpop(k, v);
                if (!m_lock[k]) begin
                    if (int'(v[0]) == k) begin
                        m_lock[k] = 1; m_exp[k] = v + 32'd2; m_good[k] = m_good[k] + 32'd1;
                    end else begin
                        add++; m_err[k] = 1;
                    end
                end else if (v == m_exp[k]) begin
                    m_exp[k] = m_exp[k] + 32'd2; m_good[k] = m_good[k] + 32'd1;
                end else begin
                    add++; m_err[k] = 1; m_lock[k] = 0;
                end
            end
            if (out_valid[k]) begin
                if (qsize(k) < int'(DEPTH)) qpush(k, din);
                else begin m_ovf[k] = 1; add++; end
            end
        end
        m_ecnt[k]  = (m_ecnt[k] + add > 65535) ? 65535 : m_ecnt[k] + add;
        m_stall[k] = (qsize(k) >= int'(STALL_THRESH));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lane%0d stall", k + 1), 32'(k == 0 ? stall_1 : stall_2),
                32'(m_stall[k]));
            chk($sformatf("lane%0d locked", k + 1), 32'(locked[k]), 32'(m_lock[k]));
            chk($sformatf("lane%0d err", k + 1), 32'(err[k]), 32'(m_err[k]));
            chk($sformatf("lane%0d overflow", k + 1), 32'(overflow[k]), 32'(m_ovf[k]));
            chk($sformatf("lane%0d err_count", k + 1),
                32'(k == 0 ? err_count_1 : err_count_2), 32'(m_ecnt[k]));
            chk($sformatf("lane%0d good_count", k + 1),
                (k == 0) ? good_count_1 : good_count_2, m_good[k]);
        end
    endtask

    // Single compare process: advance the model on each edge, then check the DUT.
    always @(posedge clk) begin
        if (reset_n) begin
            lane_step(0);
            lane_step(1);
        end
        #1 compare_all();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        out_valid = '0; drain_en = '0; flush_1 = 0; flush_2 = 0; p1 = '0; p2 = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        model_reset();
        tick();
        reset_n = 1;
    endtask

    logic [31:0] seq1, seq2;
    logic [31:0] l2_vals [6];

    initial begin
        idle();
        reset_n = 0;
        model_reset();
        #12;
        chk("reset stall_1", 32'(stall_1), 32'd0);
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset good_count_1", good_count_1, 32'd0);
        reset_n = 1;

        // Lane 1 in-order stream 0,2,4,6
        do_reset();
        out_valid = 2'b01; drain_en = 2'b01;
        for (int i = 0; i < 4; i++) begin
            p1 = 32'(2 * i);
            tick();
            if (i == 1) chk("lane1 locked after first pop", 32'(locked[0]), 32'd1);
        end
        out_valid = 2'b00;
        tick();
        chk("lane1 good_count stream", good_count_1, 32'd4);
        chk("lane1 err_count stream", 32'(err_count_1), 32'd0);

        // Lane 2 break in sequence and relock
        do_reset();
        l2_vals = '{32'd1, 32'd3, 32'd5, 32'd9, 32'd11, 32'd13};
        out_valid = 2'b10; drain_en = 2'b10;
        for (int i = 0; i < 6; i++) begin
            p2 = l2_vals[i];
            tick();
            if (i == 4) begin
                chk("lane2 unlocked on 9", 32'(locked[1]), 32'd0);
                chk("lane2 err_count on 9", 32'(err_count_2), 32'd1);
                chk("lane2 err flag on 9", 32'(err[1]), 32'd1);
            end
        end
        out_valid = 2'b00;
        tick();
        chk("lane2 relocked", 32'(locked[1]), 32'd1);
        chk("lane2 good_count", good_count_2, 32'd5);

        // Lane 1 backpressure and overflow with no drain
        do_reset();
        out_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            p1 = 32'(2 * i);
            tick();
            if (i == 0) chk("stall_1 at occ1", 32'(stall_1), 32'd0);
            if (i == 1) chk("stall_1 at occ2", 32'(stall_1), 32'd1);
            if (i == 3) chk("overflow before 5th", 32'(overflow[0]), 32'd0);
        end
        chk("overflow on 5th", 32'(overflow[0]), 32'd1);
        chk("err_count_1 on 5th", 32'(err_count_1), 32'd1);

        // Flush with 3 queued and a simultaneous push
        do_reset();
        out_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            p1 = 32'(2 * i);
            tick();
        end
        p1 = 32'd6; flush_1 = 1;
        tick();
        chk("stall_1 after flush", 32'(stall_1), 32'd0);
        chk("err_count_1 after flush", 32'(err_count_1), 32'd0);
        flush_1 = 0; out_valid = 2'b00; drain_en = 2'b01;
        tick();
        chk("good_count_1 after flush drain", good_count_1, 32'd0);

        // Sequence wrap at 2^32
        do_reset();
        out_valid = 2'b01; drain_en = 2'b01;
        p1 = 32'hFFFF_FFFC; tick();
        p1 = 32'hFFFF_FFFE; tick();
        p1 = 32'h0000_0000; tick();
        out_valid = 2'b00;
        tick();
        chk("wrap good_count_1", good_count_1, 32'd3);
        chk("wrap err_count_1", 32'(err_count_1), 32'd0);

        // Randomized traffic with a mid-burst asynchronous reset
        do_reset();
        seq1 = 32'd0;
        seq2 = 32'd1;
        for (int c = 0; c < 3000; c++) begin
            int dr;
            dr = (c < 1000) ? 1 : 3;
            out_valid[0] = ($urandom_range(0, 3) < 3);
            out_valid[1] = ($urandom_range(0, 3) < 3);
            drain_en[0]  = ($urandom_range(0, 3) < dr);
            drain_en[1]  = ($urandom_range(0, 3) < dr);
            flush_1 = ($urandom_range(0, 31) == 0);
            flush_2 = ($urandom_range(0, 31) == 0);
            p1 = ($urandom_range(0, 15) == 0) ? $urandom : seq1;
            p2 = ($urandom_range(0, 15) == 0) ? $urandom : seq2;
            if (out_valid[0]) seq1 = seq1 + 32'd2;
            if (out_valid[1]) seq2 = seq2 + 32'd2;
            if (c == 1500) begin
                #3;
                reset_n = 0;
                model_reset();
                #1;
                chk("async reset locked", 32'(locked), 32'd0);
                chk("async reset stall", 32'({stall_2, stall_1}), 32'd0);
                chk("async reset good_count_2", good_count_2, 32'd0);
                chk("async reset err_count_1", 32'(err_count_1), 32'd0);
                tick();
                reset_n = 1;
            end else begin
                tick();
            end
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
